dequant_expand: RTL and testbench



---
 rtl/dequant_pkg.sv | 52 +++++
 rtl/dequant_expand_if.sv | 22 ++
 rtl/dequant_pipe_stage.sv | 27 ++
 rtl/dequant_expand.sv | 116 +++++++++++
 tb/tb_dequant_expand.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dequant_pkg.sv
// Shared widths, payload types and the int32 saturation helper for the dequantizer.
package dequant_pkg;

  localparam int unsigned IN_W    = 8;
  localparam int unsigned DIFF_W  = 9;
  localparam int unsigned PROD_W  = 26;
  localparam int unsigned SHIFT_W = 41;
  localparam int unsigned OUT_W   = 32;
  localparam int unsigned M_W     = 16;
  localparam int unsigned L_W     = 4;
  localparam int unsigned CNT_W   = 16;

  localparam logic [OUT_W-1:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [OUT_W-1:0] INT32_MIN = 32'h8000_0000;

  typedef struct packed {
    logic              last;
    logic [DIFF_W-1:0] diff;
  } s1_t;

  typedef struct packed {
    logic              last;
    logic [PROD_W-1:0] prod;
  } s2_t;

  typedef struct packed {
    logic             last;
    logic             sat;
    logic [OUT_W-1:0] data;
  } s3_t;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } sat_t;

  // Fits in int32 only when bits [SHIFT_W-1:OUT_W-1] are all copies of the sign.
  function automatic sat_t saturate(input logic [SHIFT_W-1:0] w);
    sat_t                     r;
    logic [SHIFT_W-OUT_W:0]   upper;
    upper  = w[SHIFT_W-1:OUT_W-1];
    r.sat  = !((upper == '0) || (upper == '1));
    if (!r.sat)
      r.data = w[OUT_W-1:0];
    else if (w[SHIFT_W-1])
      r.data = INT32_MIN;
    else
      r.data = INT32_MAX;
    return r;
  endfunction

endpackage

// File: rtl/dequant_expand_if.sv
// Valid/ready stream bundle: int8 elements in, int32 elements with frame tag out.
interface dequant_expand_if;
  import dequant_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dequant_pipe_stage.sv
// Generic valid/ready register slice; loads whenever it is empty or its contents move on.
module dequant_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         down_ready,
  output logic         adv_c,
  output logic         valid,
  output logic [W-1:0] data
);

  assign adv_c = !valid || down_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (adv_c) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/dequant_expand.sv
// Streaming int8 -> int32 dequantizer: subtract zero point, scale, shift, saturate; 3-stage pipe.
module dequant_expand
  import dequant_pkg::*;
#(
  parameter logic [M_W-1:0]       M1        = 16'd1,
  parameter logic [L_W-1:0]       L         = 4'd0,
  parameter logic signed [IN_W-1:0] ZP      = 8'sd0,
  parameter logic [CNT_W-1:0]     FRAME_LEN = 16'd64
) (
  input  logic             clk,
  input  logic             rst,
  dequant_expand_if.slave  bus,
  input  logic             sat_clr,
  output logic             sat_flag
);

  localparam int unsigned S1_W = $bits(s1_t);
  localparam int unsigned S2_W = $bits(s2_t);
  localparam int unsigned S3_W = $bits(s3_t);

  s1_t s1_in, s1_q;
  s2_t s2_in, s2_q;
  s3_t s3_in, s3_q;
  logic v1, v2, v3;
  logic adv1, adv2, adv3;
  logic [CNT_W-1:0] cnt;
  logic accept;
  logic frame_end_c;
  logic signed [SHIFT_W-1:0] ext_c;
  logic signed [SHIFT_W-1:0] shifted_c;
  sat_t sat_c;

  assign accept      = bus.in_valid && adv1;
  assign frame_end_c = (cnt == FRAME_LEN - 16'd1);

  // Frame position of the next accepted element.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (accept)
      cnt <= frame_end_c ? '0 : cnt + 16'd1;
  end

  always_comb begin
    s1_in      = '0;
    s1_in.last = frame_end_c;
    s1_in.diff = $signed({bus.in_data[IN_W-1], bus.in_data}) - $signed({ZP[IN_W-1], ZP});
  end

  always_comb begin
    s2_in      = '0;
    s2_in.last = s1_q.last;
    s2_in.prod = $signed({{(PROD_W-DIFF_W){s1_q.diff[DIFF_W-1]}}, s1_q.diff})
               * $signed({{(PROD_W-M_W){1'b0}}, M1});
  end

  // Product is well inside 26 bits, so a 15-bit shift cannot wrap in 41 bits.
  always_comb begin
    ext_c      = $signed({{(SHIFT_W-PROD_W){s2_q.prod[PROD_W-1]}}, s2_q.prod});
    shifted_c  = ext_c <<< L;
    sat_c      = saturate(shifted_c);
    s3_in      = '0;
    s3_in.last = s2_q.last;
    s3_in.sat  = sat_c.sat;
    s3_in.data = sat_c.data;
  end

  dequant_pipe_stage #(.W(S1_W)) u_st1 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (bus.in_valid),
    .up_data    (s1_in),
    .down_ready (adv2),
    .adv_c      (adv1),
    .valid      (v1),
    .data       (s1_q)
  );

  dequant_pipe_stage #(.W(S2_W)) u_st2 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (v1),
    .up_data    (s2_in),
    .down_ready (adv3),
    .adv_c      (adv2),
    .valid      (v2),
    .data       (s2_q)
  );

  dequant_pipe_stage #(.W(S3_W)) u_st3 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (v2),
    .up_data    (s3_in),
    .down_ready (bus.out_ready),
    .adv_c      (adv3),
    .valid      (v3),
    .data       (s3_q)
  );

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3;
  assign bus.out_data  = s3_q.data;
  assign bus.out_last  = s3_q.last;

  // Sticky saturation report; a saturated element leaving wins over a clear.
  always_ff @(posedge clk) begin
    if (rst)
      sat_flag <= 1'b0;
    else if (v3 && bus.out_ready && s3_q.sat)
      sat_flag <= 1'b1;
    else if (sat_clr)
      sat_flag <= 1'b0;
  end

endmodule

// File: tb/tb_dequant_expand.sv
// Four differently parameterised dequantizers driven by one stream, each checked against an arithmetic model.
module tb_dequant_expand;

  localparam int ND = 4;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        sat;
    int          e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sat_clr;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        rdy [ND];
  logic        ov  [ND];
  logic [31:0] od  [ND];
  logic        ol  [ND];
  logic        sf  [ND];

  dequant_expand_if b0 ();
  dequant_expand_if b1 ();
  dequant_expand_if b2 ();
  dequant_expand_if b3 ();

  dequant_expand #(.M1(16'd1), .L(4'd0), .ZP(8'sd0), .FRAME_LEN(16'd4)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .sat_clr(sat_clr), .sat_flag(sf[0]));
  dequant_expand #(.M1(16'd65535), .L(4'd15), .ZP(-8'sd128), .FRAME_LEN(16'd1)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .sat_clr(sat_clr), .sat_flag(sf[1]));
  dequant_expand #(.M1(16'd65535), .L(4'd15), .ZP(8'sd127), .FRAME_LEN(16'd64)) u2 (
    .clk(clk), .rst(rst), .bus(b2), .sat_clr(sat_clr), .sat_flag(sf[2]));
  dequant_expand #(.M1(16'd3), .L(4'd4), .ZP(8'sd5), .FRAME_LEN(16'd7)) u3 (
    .clk(clk), .rst(rst), .bus(b3), .sat_clr(sat_clr), .sat_flag(sf[3]));

  assign b0.in_valid = in_valid;  assign b0.in_data = in_data;  assign b0.out_ready = out_ready;
  assign b1.in_valid = in_valid;  assign b1.in_data = in_data;  assign b1.out_ready = out_ready;
  assign b2.in_valid = in_valid;  assign b2.in_data = in_data;  assign b2.out_ready = out_ready;
  assign b3.in_valid = in_valid;  assign b3.in_data = in_data;  assign b3.out_ready = out_ready;

  assign rdy[0] = b0.in_ready; assign ov[0] = b0.out_valid; assign od[0] = b0.out_data; assign ol[0] = b0.out_last;
  assign rdy[1] = b1.in_ready; assign ov[1] = b1.out_valid; assign od[1] = b1.out_data; assign ol[1] = b1.out_last;
  assign rdy[2] = b2.in_ready; assign ov[2] = b2.out_valid; assign od[2] = b2.out_data; assign ol[2] = b2.out_last;
  assign rdy[3] = b3.in_ready; assign ov[3] = b3.out_valid; assign od[3] = b3.out_data; assign ol[3] = b3.out_last;

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          edge_n = 0;
  int          n_acc = 0;
  exp_t        q [ND][$];
  logic [31:0] log_d [ND][$];
  logic        log_l [ND][$];
  int          mcnt [ND];
  logic        msat [ND];
  logic        prev_stall [ND];
  logic [31:0] prev_od [ND];
  logic        prev_ol [ND];

  function automatic int zp_of(int d);
    case (d) 0: return 0; 1: return -128; 2: return 127; default: return 5; endcase
  endfunction
  function automatic int m1_of(int d);
    case (d) 0: return 1; 1: return 65535; 2: return 65535; default: return 3; endcase
  endfunction
  function automatic int l_of(int d);
    case (d) 0: return 0; 1: return 15; 2: return 15; default: return 4; endcase
  endfunction
  function automatic int fl_of(int d);
    case (d) 0: return 4; 1: return 1; 2: return 64; default: return 7; endcase
  endfunction

  // Plain integer arithmetic: (x - zp) * m1 * 2^l, clipped to the int32 range.
  function automatic exp_t model(int d, logic [7:0] x);
    exp_t   r;
    longint w;
    longint maxv;
    longint minv;
    maxv = 64'sd2147483647;
    minv = -maxv - 1;
    w = (longint'($signed(x)) - longint'(zp_of(d))) * longint'(m1_of(d));
    w = w * (longint'(1) << l_of(d));
    r.last = 1'b0;
    r.e    = 0;
    if (w > maxv) begin
      r.data = 32'h7FFF_FFFF; r.sat = 1'b1;
    end else if (w < minv) begin
      r.data = 32'h8000_0000; r.sat = 1'b1;
    end else begin
      r.data = 32'(w); r.sat = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < ND; d++) begin
      q[d].delete();
      mcnt[d]       = 0;
      msat[d]       = 1'b0;
      prev_stall[d] = 1'b0;
    end
  endtask

  task automatic clear_logs();
    for (int d = 0; d < ND; d++) begin
      log_d[d].delete();
      log_l[d].delete();
    end
  endtask

  // Inputs are set at the falling edge; sample, check, then let one rising edge pass.
  task automatic cycle();
    logic acc;
    logic ev;
    exp_t e;
    #1;
    acc = in_valid && rdy[0];
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("in_ready[%0d]", d), 64'(rdy[d]), 64'((q[d].size() < 3) || out_ready));
      ev = (q[d].size() > 0) && (edge_n >= q[d][0].e + 2);
      chk($sformatf("out_valid[%0d]", d), 64'(ov[d]), 64'(ev));
      if (ev && ov[d]) begin
        chk($sformatf("out_data[%0d]", d), 64'(od[d]), 64'(q[d][0].data));
        chk($sformatf("out_last[%0d]", d), 64'(ol[d]), 64'(q[d][0].last));
      end
      if (prev_stall[d]) begin
        chk($sformatf("hold_valid[%0d]", d), 64'(ov[d]), 64'(1));
        chk($sformatf("hold_data[%0d]", d), 64'(od[d]), 64'(prev_od[d]));
        chk($sformatf("hold_last[%0d]", d), 64'(ol[d]), 64'(prev_ol[d]));
      end
      chk($sformatf("sat_flag[%0d]", d), 64'(sf[d]), 64'(msat[d]));
      if (ov[d] && out_ready) begin
        log_d[d].push_back(od[d]);
        log_l[d].push_back(ol[d]);
        if (q[d].size() > 0) begin
          e = q[d].pop_front();
          if (e.sat) msat[d] = 1'b1;
          else if (sat_clr) msat[d] = 1'b0;
        end else if (sat_clr) msat[d] = 1'b0;
      end else if (sat_clr) msat[d] = 1'b0;
      prev_stall[d] = ov[d] && !out_ready;
      prev_od[d]    = od[d];
      prev_ol[d]    = ol[d];
      if (acc) begin
        e      = model(d, in_data);
        e.last = (mcnt[d] == fl_of(d) - 1);
        e.e    = edge_n + 1;
        mcnt[d] = e.last ? 0 : mcnt[d] + 1;
        q[d].push_back(e);
      end
    end
    if (acc) n_acc++;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic rst_cycle();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic drain();
    int left;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      left = 0;
      for (int d = 0; d < ND; d++) left += q[d].size();
      if (left == 0) break;
      cycle();
    end
    for (int d = 0; d < ND; d++)
      chk($sformatf("drain_empty[%0d]", d), 64'(q[d].size()), 64'(0));
  endtask

  task automatic send(input logic [7:0] x);
    in_valid = 1'b1;
    in_data  = x;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vec [4];
    rst = 1'b1; sat_clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    clear_model();
    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_out_valid[%0d]", d), 64'(ov[d]), 64'(0));
      chk($sformatf("rst_out_data[%0d]", d), 64'(od[d]), 64'(0));
      chk($sformatf("rst_out_last[%0d]", d), 64'(ol[d]), 64'(0));
      chk($sformatf("rst_sat_flag[%0d]", d), 64'(sf[d]), 64'(0));
      chk($sformatf("rst_in_ready[%0d]", d), 64'(rdy[d]), 64'(1));
    end

    // Back-to-back extremes plus a mid-range value.
    vec = '{8'h80, 8'h00, 8'h7F, 8'hF9};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(vec[i]);
    drain();
    chk("basic_count", 64'(log_d[0].size()), 64'(4));
    chk("basic_m128", 64'(log_d[0][0]), 64'(32'hFFFF_FF80));
    chk("basic_zero", 64'(log_d[0][1]), 64'(32'h0000_0000));
    chk("basic_p127", 64'(log_d[0][2]), 64'(32'h0000_007F));
    chk("scale_m7", 64'(log_d[3][3]), 64'(32'hFFFF_FDC0));
    chk("sat_max", 64'(log_d[1][2]), 64'(32'h7FFF_FFFF));
    chk("sat_min", 64'(log_d[2][0]), 64'(32'h8000_0000));
    chk("no_sat_flag", 64'(sf[0]), 64'(0));
    chk("sat_flag_set", 64'(sf[1]), 64'(1));
    sat_clr = 1'b1;
    cycle();
    sat_clr = 1'b0;
    chk("sat_flag_clr", 64'(sf[1]), 64'(0));

    // Fill with the output blocked, then release it.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'($urandom));
    #1;
    chk("full_in_ready", 64'(rdy[0]), 64'(0));
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 64'(rdy[0]), 64'(1));
    send(8'($urandom));
    drain();

    // Frame tagging from a fresh frame start.
    rst_cycle();
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(8'($urandom));
    drain();
    for (int i = 0; i < 10; i++)
      chk($sformatf("frame_last_%0d", i), 64'(log_l[0][i]), 64'((i == 3) || (i == 7)));
    for (int i = 0; i < 2; i++) send(8'($urandom));
    drain();
    chk("frame_tail_a", 64'(log_l[0][10]), 64'(0));
    chk("frame_tail_b", 64'(log_l[0][11]), 64'(1));

    // Reset with two elements in flight.
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) send(8'($urandom));
    rst_cycle();
    #1;
    chk("midrst_out_valid", 64'(ov[0]), 64'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'($urandom));
    drain();
    chk("midrst_count", 64'(log_d[0].size()), 64'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("midrst_last_%0d", i), 64'(log_l[0][i]), 64'(i == 3));

    // Random traffic with random backpressure and occasional clears.
    n_acc = 0;
    for (int c = 0; c < 6000 && n_acc < 1000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      sat_clr   = ($urandom_range(0, 9) == 0);
      cycle();
    end
    chk("random_accepted", 64'(n_acc), 64'(1000));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
